// File: rtl/apu_clock_aux_core.sv
// APU harness clock source: CPU phases PHI0/1/2, half-rate ACLK, and a Q16
// mixer that turns channel DAC codes into AOut (squares) and BOut (tri/noise/DMC).
module apu_clock_aux_core #(
  parameter int unsigned DIV   = 12,
  parameter int unsigned W_SQ  = 493,
  parameter int unsigned W_TRI = 558,
  parameter int unsigned W_NOI = 324,
  parameter int unsigned W_DMC = 220
) (
  input  logic        CLK,
  input  logic        RES,
  output logic        PHI0,
  output logic        PHI1,
  output logic        PHI2,
  output logic        ACLK,
  output logic        n_ACLK,
  input  logic [7:0]  AUX_A,
  input  logic [14:0] AUX_B,
  output logic [31:0] AOut,
  output logic [31:0] BOut
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wrap;
  logic          toggle;
  logic [4:0]    sq_sum;
  logic [31:0]   a_mix;
  logic [31:0]   b_mix;

  assign wrap    = (cnt == CNT_LAST);
  assign cnt_nxt = wrap ? '0 : cnt + CW'(1);

  assign sq_sum = {1'b0, AUX_A[3:0]} + {1'b0, AUX_A[7:4]};
  assign a_mix  = W_SQ * {27'd0, sq_sum};
  assign b_mix  = W_TRI * {28'd0, AUX_B[3:0]}
                + W_NOI * {28'd0, AUX_B[7:4]}
                + W_DMC * {25'd0, AUX_B[14:8]};

  // PHI0 is registered from the next count so it lines up with cnt itself:
  // low while cnt is in the first half, high in the second.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt    <= '0;
      toggle <= 1'b0;
      PHI0   <= 1'b0;
      AOut   <= '0;
      BOut   <= '0;
    end else begin
      cnt  <= cnt_nxt;
      PHI0 <= (cnt_nxt >= CNT_HALF);
      if (wrap)
        toggle <= ~toggle;
      AOut <= a_mix;
      BOut <= b_mix;
    end
  end

  assign PHI1   = ~PHI0;
  assign PHI2   = PHI0;
  assign ACLK   = toggle;
  assign n_ACLK = ~toggle;

endmodule

// File: tb/tb_apu_clock_aux_core.sv
// Directed bench for apu_clock_aux_core: per-cycle scoreboard of expected
// phase/ACLK/mixer outputs plus targeted boundary checks.
module tb_apu_clock_aux_core;

  logic        CLK;
  logic        RES;
  logic        PHI0, PHI1, PHI2, ACLK, n_ACLK;
  logic [7:0]  AUX_A;
  logic [14:0] AUX_B;
  logic [31:0] AOut, BOut;

  apu_clock_aux_core dut (
    .CLK(CLK), .RES(RES),
    .PHI0(PHI0), .PHI1(PHI1), .PHI2(PHI2),
    .ACLK(ACLK), .n_ACLK(n_ACLK),
    .AUX_A(AUX_A), .AUX_B(AUX_B),
    .AOut(AOut), .BOut(BOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        phi0;
    logic        aclk;
    logic [31:0] aout;
    logic [31:0] bout;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  logic m_tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model for the coming edge, queue its prediction,
  // then clock once and compare every output against the popped entry.
  task automatic step();
    exp_t e;
    logic np, na;
    if (RES) begin
      m_cnt = 0;
      m_tog = 1'b0;
    end else if (m_cnt == 11) begin
      m_cnt = 0;
      m_tog = ~m_tog;
    end else begin
      m_cnt++;
    end
    e.phi0 = (m_cnt >= 6);
    e.aclk = m_tog;
    e.aout = RES ? 32'd0 : 32'd493 * (32'(AUX_A[3:0]) + 32'(AUX_A[7:4]));
    e.bout = RES ? 32'd0 : 32'd558 * 32'(AUX_B[3:0]) + 32'd324 * 32'(AUX_B[7:4])
                          + 32'd220 * 32'(AUX_B[14:8]);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e  = sb.pop_front();
    np = ~e.phi0;
    na = ~e.aclk;
    check("PHI0", PHI0, e.phi0);
    check("PHI1", PHI1, np);
    check("PHI2", PHI2, e.phi0);
    check("ACLK", ACLK, e.aclk);
    check("n_ACLK", n_ACLK, na);
    check("AOut", AOut, e.aout);
    check("BOut", BOut, e.bout);
  endtask

  initial begin
    int   rise;
    int   arise;
    int   run;
    logic seen;
    logic prev_a, prev_p;

    RES   = 1'b1;
    AUX_A = 8'hFF;
    AUX_B = 15'h7FFF;
    repeat (6) step();
    check("rst_PHI0", PHI0, 1'b0);
    check("rst_n_ACLK", n_ACLK, 1'b1);
    check("rst_AOut", AOut, 32'd0);

    RES   = 1'b0;
    AUX_A = 8'h00;
    AUX_B = 15'h0000;
    rise  = -1;
    arise = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (PHI0 === 1'b1 && rise < 0) rise = i;
      if (ACLK === 1'b1 && arise < 0) arise = i;
    end
    check("phi0_rise_after_release", rise, 32'd6);
    check("aclk_rise_after_release", arise, 32'd12);

    prev_a = ACLK;
    prev_p = PHI0;
    run    = 0;
    seen   = 1'b0;
    for (int i = 0; i < 220; i++) begin
      step();
      run++;
      if (ACLK !== prev_a) begin
        check("aclk_edge_at_phi0_fall", {prev_p, PHI0}, 2'b10);
        if (seen) check("aclk_half_period", run, 32'd12);
        seen = 1'b1;
        run  = 0;
      end
      prev_a = ACLK;
      prev_p = PHI0;
    end

    AUX_B = 15'h00F0; step(); check("BOut_noise15", BOut, 32'd4860);
    AUX_B = 15'h7FFF; step(); check("BOut_full", BOut, 32'd41170);
    AUX_B = 15'h0000; step(); check("BOut_zero", BOut, 32'd0);
    AUX_A = 8'hFF;    step(); check("AOut_full", AOut, 32'd14790);
    AUX_A = 8'h21;    step(); check("AOut_21", AOut, 32'd1479);
    for (int i = 0; i < 24; i++) begin
      AUX_A = 8'($urandom);
      AUX_B = 15'($urandom);
      step();
    end

    AUX_A = 8'hFF;
    AUX_B = 15'h7FFF;
    for (int i = 0; i < 48 && !(m_cnt == 8 && m_tog == 1'b1); i++) step();
    check("pre_reset_ACLK", ACLK, 1'b1);
    check("pre_reset_PHI0", PHI0, 1'b1);
    RES = 1'b1;
    step();
    check("midrst_PHI0", PHI0, 1'b0);
    check("midrst_ACLK", ACLK, 1'b0);
    check("midrst_n_ACLK", n_ACLK, 1'b1);
    check("midrst_AOut", AOut, 32'd0);
    check("midrst_BOut", BOut, 32'd0);
    RES   = 1'b0;
    rise  = -1;
    arise = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (PHI0 === 1'b1 && rise < 0) rise = i;
      if (ACLK === 1'b1 && arise < 0) arise = i;
    end
    check("restart_phi0_rise", rise, 32'd6);
    check("restart_aclk_rise", arise, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
